fetch_queue_unit: RTL and testbench

Parametrised next-generation instruction fetch front end. It owns the fetch PC and issues word requests to an instruction memory over a valid/ready request port with a variable-latency response. It buffers returned instructions with their PCs in a QUEUE_DEPTH-entry FIFO that feeds decode. Branch/redo redirects flush the queue and discard any in-flight response. Sits between the instruction cache and the decode/hazard stage, and decouples cache-miss latency from decode stalls.

---
 rtl/fetch_queue_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction fetch front end. Owns the fetch PC, issues one word
//            request at a time to instruction memory, and buffers returned
//            {pc, instruction} pairs in a QUEUE_DEPTH-entry FIFO that feeds
//            decode. A redirect flushes the FIFO, reloads the fetch PC, and
//            throws away any response still in flight.
// Ports    : clk, reset_n (async, active low)
//            redirect_valid / redirect_target  - flush and refetch
//            imem_req_valid / imem_req_addr / imem_req_ready - request port
//            imem_rsp_valid / imem_rsp_data    - response for the one
//                                                outstanding request
//            dec_valid / dec_ready / dec_pc / dec_instruction /
//            dec_rs1 / dec_rs2                 - FIFO head to decode
//            queue_count                       - occupied FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_target,
    output logic                           imem_req_valid,
    output logic [31:0]                    imem_req_addr,
    input  logic                           imem_req_ready,
    input  logic                           imem_rsp_valid,
    input  logic [31:0]                    imem_rsp_data,
    output logic                           dec_valid,
    input  logic                           dec_ready,
    output logic [31:0]                    dec_pc,
    output logic [31:0]                    dec_instruction,
    output logic [4:0]                     dec_rs1,
    output logic [4:0]                     dec_rs2,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(QUEUE_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_pending_pc;
    logic               r_outstanding;
    logic               r_drop;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_pc_mem    [QUEUE_DEPTH];
    logic [31:0]        r_instr_mem [QUEUE_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_cnt_w:0] w_occupancy;
    logic             w_space;
    logic             w_req_fire;
    logic             w_rsp_accept;
    logic             w_push;
    logic             w_pop;

    // Entries held plus the one that may still land. A same-cycle pop is
    // deliberately not credited, which keeps the FIFO overflow-free without
    // a path from dec_ready to the request port.
    assign w_occupancy = {1'b0, r_count} + (c_cnt_w + 1)'(r_outstanding);
    assign w_space     = (w_occupancy < c_depth);

    // A new request may go out when the port is idle or the outstanding
    // response is returning this very cycle.
    assign imem_req_valid = reset_n & ~redirect_valid
                          & (~r_outstanding | imem_rsp_valid) & w_space;
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire   = imem_req_valid & imem_req_ready;
    assign w_rsp_accept = imem_rsp_valid & r_outstanding;

    // Redirect overrides every queue movement in its cycle.
    assign w_push = w_rsp_accept & ~r_drop & ~redirect_valid;
    assign w_pop  = dec_valid & dec_ready & ~redirect_valid;

    assign dec_valid       = (r_count != '0);
    assign dec_pc          = r_pc_mem[r_rd_ptr];
    assign dec_instruction = r_instr_mem[r_rd_ptr];
    assign dec_rs1         = dec_instruction[19:15];
    assign dec_rs2         = dec_instruction[24:20];
    assign queue_count     = r_count;

    // ------------------------------------------------------------------
    // Fetch PC, request tracking and drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_pending_pc  <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_target;
            if (r_outstanding && !imem_rsp_valid) begin
                // Response still on its way: keep tracking it but mark it
                // stale so it is discarded on arrival.
                r_drop <= 1'b1;
            end else begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
        end else begin
            if (w_req_fire) begin
                r_outstanding <= 1'b1;
                r_pending_pc  <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else if (w_rsp_accept) begin
                r_outstanding <= 1'b0;
            end
            if (w_rsp_accept) begin
                r_drop <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage; cleared on reset so decode sees zeros until the first
    // instruction lands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_pending_pc;
            r_instr_mem[r_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Randomised scoreboard bench for fetch_queue_unit. A behavioural
//            memory tags each in-flight request as stale when a redirect
//            passes it; live responses are queued as expected decode
//            entries, and a negedge monitor compares the DUT against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instruction;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [$clog2(DEPTH):0] queue_count;

    fetch_queue_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_instruction (dec_instruction),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];          // expected decode stream
    logic [31:0] exp_pc = RPC;      // expected next fetch address
    bit          mem_busy  = 1'b0;  // a request is in flight
    bit          mem_stale = 1'b0;  // a redirect passed it
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_data  = '0;
    int          mem_lat   = 0;

    int k_lat_max       = 0;
    int k_ready_pct     = 100;
    int k_req_ready_pct = 100;
    int k_redir_pct     = 0;
    int k_spur_pct      = 0;
    bit k_wrap          = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic idle_inputs();
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        dec_ready       = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc    = RPC;
        mem_busy  = 1'b0;
        mem_stale = 1'b0;
        mem_lat   = 0;
    endtask

    // One clock of stimulus followed by the model bookkeeping for that clock.
    task automatic drive_cycle();
        bit rsp_acc;
        @(posedge clk);
        #1;
        redirect_valid  = ($urandom_range(99, 0) < k_redir_pct);
        redirect_target = k_wrap ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
        dec_ready       = ($urandom_range(99, 0) < k_ready_pct);
        imem_req_ready  = ($urandom_range(99, 0) < k_req_ready_pct);
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = $urandom();
        if (mem_busy) begin
            if (mem_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data;
            end else begin
                mem_lat--;
            end
        end else if ($urandom_range(99, 0) < k_spur_pct) begin
            imem_rsp_valid = 1'b1;   // stray response with nothing in flight
        end

        @(negedge clk);
        #1;
        rsp_acc = imem_rsp_valid && mem_busy;
        if (redirect_valid)
            exp_q.delete();
        else if (rsp_acc && !mem_stale)
            exp_q.push_back('{pc: mem_addr, instr: mem_data});
        if (rsp_acc)
            mem_busy = 1'b0;
        else if (redirect_valid && mem_busy)
            mem_stale = 1'b1;
        if (imem_req_valid && imem_req_ready) begin
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_addr  = exp_pc;
            mem_data  = $urandom();
            mem_lat   = int'($urandom_range(k_lat_max, 0));
            exp_pc    = exp_pc + 32'd4;
        end
        if (redirect_valid)
            exp_pc = redirect_target;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        bit   exp_req;
        ent_t e;
        if (!reset_n) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_dec_valid", dec_valid, 0);
        end else begin
            exp_req = !redirect_valid && (!mem_busy || imem_rsp_valid)
                      && ((exp_q.size() + int'(mem_busy)) < DEPTH);
            chk("req_valid", imem_req_valid, exp_req);
            if (imem_req_valid)
                chk("req_addr", imem_req_addr, exp_pc);
            chk("dec_valid", dec_valid, exp_q.size() != 0);
            chk("queue_count", 32'(queue_count), exp_q.size());
            if (dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pop_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_instr", dec_instruction, e.instr);
                    chk("dec_rs1", 32'(dec_rs1), 32'(e.instr[19:15]));
                    chk("dec_rs2", 32'(dec_rs2), 32'(e.instr[24:20]));
                end
            end
        end
    end

    initial begin
        int n;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_count", 32'(queue_count), 0);
        chk("reset_dec_valid", dec_valid, 0);
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_dec_pc", dec_pc, 0);
        chk("reset_dec_instr", dec_instruction, 0);
        reset_n = 1'b1;

        // Single-cycle memory, decode always ready.
        k_lat_max = 0; k_ready_pct = 100; k_req_ready_pct = 100;
        k_redir_pct = 0; k_spur_pct = 0;
        run(40);

        // Decode stalls: queue fills and requests stop.
        k_ready_pct = 0;
        run(14);
        chk("full_count", 32'(queue_count), DEPTH);
        chk("full_req_valid", imem_req_valid, 0);
        k_ready_pct = 100;
        run(20);

        // General random traffic with variable latency and redirects.
        k_lat_max = 5; k_ready_pct = 70; k_req_ready_pct = 70;
        k_redir_pct = 8; k_spur_pct = 10;
        run(1500);

        // Fetch PC wrapping past the top of the address space.
        k_wrap = 1'b1; k_redir_pct = 5; k_lat_max = 2; k_ready_pct = 80;
        run(300);
        k_wrap = 1'b0;

        // Redirect-heavy traffic.
        k_redir_pct = 25; k_ready_pct = 50; k_lat_max = 3; k_spur_pct = 20;
        run(800);

        // Build outstanding=1 with two queued entries, then reset mid-flight.
        k_redir_pct = 100; k_spur_pct = 0;
        run(1);
        k_redir_pct = 0; k_ready_pct = 0; k_lat_max = 0; k_req_ready_pct = 100;
        n = 0;
        while (!(exp_q.size() == 2 && mem_busy) && n < 100) begin
            drive_cycle();
            n++;
        end
        chk("midflight_setup", (exp_q.size() == 2 && mem_busy), 1);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_count", 32'(queue_count), 0);
        chk("mid_rst_dec_valid", dec_valid, 0);
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_dec_pc", dec_pc, 0);
        chk("mid_rst_dec_instr", dec_instruction, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        // Late responses before any request is accepted must be ignored.
        k_req_ready_pct = 0; k_spur_pct = 100; k_ready_pct = 100;
        run(3);
        chk("late_rsp_count", 32'(queue_count), 0);

        k_lat_max = 4; k_ready_pct = 75; k_req_ready_pct = 80;
        k_redir_pct = 6; k_spur_pct = 10;
        run(400);

        chk("pops_seen", (pops > 200), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
